// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline registers.
package pipe_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;

   localparam logic [31:0] RV_NOP = 32'h00000013;

   // Number of held entries implied by a state.
   function automatic logic [1:0] state_occ(input pipe_state_t s);
      case (s)
         ONE:     return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc && (count_reg != {W{1'b1}}))
         count_next = count_reg + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer, flush with NOP
// insertion and a saturating downstream-stall counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'({32'h0, RV_NOP}),
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);

   pipe_state_t      state_reg, state_next;
   logic [WIDTH-1:0] main_reg, main_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic [1:0]       occ_reg;
   logic             in_fire;
   logic             out_fire;

   // Handshake outputs come straight from registered state, so neither
   // out_ready nor in_* has a combinational path to the other side.
   assign in_ready  = (state_reg != FULL);
   assign out_valid = (state_reg != EMPTY);
   assign out_data  = main_reg;
   assign occupancy = occ_reg;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (flush) begin
         state_next = EMPTY;
         main_next  = NOP_VALUE;
         skid_next  = NOP_VALUE;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  state_next = ONE;
                  main_next  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_next = in_data;
               end else if (in_fire) begin
                  state_next = FULL;
                  skid_next  = in_data;
               end else if (out_fire) begin
                  state_next = EMPTY;
                  main_next  = NOP_VALUE;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_next = ONE;
                  main_next  = skid_reg;
                  skid_next  = NOP_VALUE;
               end
            end
            default: begin
               state_next = EMPTY;
               main_next  = NOP_VALUE;
               skid_next  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EMPTY;
         main_reg  <= NOP_VALUE;
         skid_reg  <= NOP_VALUE;
         occ_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
         occ_reg   <= state_occ(state_next);
      end
   end

   // Stalls keep counting through flushes; only reset clears them.
   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (out_valid & ~out_ready),
      .count(stall_count)
   );

endmodule
